// File: rtl/motorb_dense_seq_mac_if.sv
// Bundles the ap_* handshake, activation/result vectors and the weight ROM port of the motorB dense layer.
// slave is the layer's view; master is the controller/ROM side that drives start, activations and ROM data.
interface motorb_dense_seq_mac_if #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 9,
  parameter int AW    = 7
);
  logic                  ap_start;
  logic                  ap_idle;
  logic                  ap_ready;
  logic                  ap_done;
  logic [32*N_IN-1:0]    in_data;
  logic [AW-1:0]         rom_addr;
  logic                  rom_ce;
  logic [31:0]           rom_q;
  logic [32*N_OUT-1:0]   ap_return;

  modport slave (
    input  ap_start, in_data, rom_q,
    output ap_idle, ap_ready, ap_done, rom_addr, rom_ce, ap_return
  );

  modport master (
    output ap_start, in_data, rom_q,
    input  ap_idle, ap_ready, ap_done, rom_addr, rom_ce, ap_return
  );
endinterface

// File: rtl/motorb_dense_seq_mac.sv
// Time-multiplexed fully-connected layer: one MAC walks bias+weights from ROM, one neuron after another.
// Optional macro MOTORB_DENSE_SAT_EN saturates each result to 32 bits instead of wrapping.
module motorb_dense_seq_mac #(
  parameter int N_IN  = 9,
  parameter int N_OUT = 9,
  parameter int FRAC  = 24,
  parameter int AW    = 7
) (
  input logic                   ap_clk,
  input logic                   ap_rst,
  motorb_dense_seq_mac_if.slave bus
);

  localparam int T  = N_OUT * (N_IN + 1);
  localparam int IW = $clog2(N_IN + 1);
  localparam int NW = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             rom_addr_q, rom_addr_d;
  logic                      rom_ce_q, rom_ce_d;
  logic                      rom_vld_q, rom_vld_d;
  logic [32*N_IN-1:0]        x_lat_q, x_lat_d;
  logic [32*N_IN-1:0]        x_cur_q, x_cur_d;
  logic [IW-1:0]             in_idx_q, in_idx_d;
  logic [NW-1:0]             neu_idx_q, neu_idx_d;
  logic signed [67:0]        acc_q, acc_d;
  logic [32*N_OUT-1:0]       ret_q, ret_d;

  logic                      accept;
  logic signed [63:0]        x_ext;
  logic signed [63:0]        w_ext;
  logic signed [63:0]        prod;
  logic signed [67:0]        bias_ext;
  logic signed [67:0]        sum;
  logic [31:0]               res;
`ifdef MOTORB_DENSE_SAT_EN
  logic signed [67:0]        shifted;
  localparam logic signed [67:0] SAT_MAX = 68'sd2147483647;
  localparam logic signed [67:0] SAT_MIN = -68'sd2147483648;
`endif

  assign accept = (state_q == S_IDLE) && bus.ap_start;

  // Fetch side: one ROM read per RUN cycle, data returns on the following cycle (rom_vld).
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_ce_d   = 1'b0;
    rom_vld_d  = rom_ce_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          state_d    = S_RUN;
          rom_ce_d   = 1'b1;
          rom_addr_d = '0;
        end
      end
      S_RUN: begin
        if (rom_addr_q == AW'(T - 1)) begin
          state_d = S_DRAIN;
        end else begin
          rom_ce_d   = 1'b1;
          rom_addr_d = rom_addr_q + AW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign x_ext    = {{32{x_cur_q[31]}}, x_cur_q[31:0]};
  assign w_ext    = {{32{bus.rom_q[31]}}, bus.rom_q};
  assign prod     = x_ext * w_ext;
  assign bias_ext = {{36{bus.rom_q[31]}}, bus.rom_q};
  assign sum      = acc_q + {{4{prod[63]}}, prod};

`ifdef MOTORB_DENSE_SAT_EN
  always_comb begin
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX) begin
      res = 32'h7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      res = 32'h8000_0000;
    end else begin
      res = shifted[31:0];
    end
  end
`else
  assign res = sum[FRAC+31:FRAC];
`endif

  // Accumulate side: in_idx 0 is the bias slot, 1..N_IN the weights; the working copy of the
  // activations is reloaded at each bias and shifted down one word per weight.
  always_comb begin
    x_lat_d   = x_lat_q;
    x_cur_d   = x_cur_q;
    in_idx_d  = in_idx_q;
    neu_idx_d = neu_idx_q;
    acc_d     = acc_q;
    ret_d     = ret_q;
    if (accept) begin
      x_lat_d   = bus.in_data;
      in_idx_d  = '0;
      neu_idx_d = '0;
    end else if (rom_vld_q) begin
      if (in_idx_q == '0) begin
        acc_d    = bias_ext <<< FRAC;
        x_cur_d  = x_lat_q;
        in_idx_d = IW'(1);
      end else begin
        acc_d   = sum;
        x_cur_d = x_cur_q >> 32;
        if (in_idx_q == IW'(N_IN)) begin
          in_idx_d  = '0;
          neu_idx_d = neu_idx_q + NW'(1);
          for (int j = 0; j < N_OUT; j++) begin
            if (neu_idx_q == NW'(j)) begin
              ret_d[32*j +: 32] = res;
            end
          end
        end else begin
          in_idx_d = in_idx_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      rom_ce_q   <= 1'b0;
      rom_vld_q  <= 1'b0;
      x_lat_q    <= '0;
      x_cur_q    <= '0;
      in_idx_q   <= '0;
      neu_idx_q  <= '0;
      acc_q      <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_ce_q   <= rom_ce_d;
      rom_vld_q  <= rom_vld_d;
      x_lat_q    <= x_lat_d;
      x_cur_q    <= x_cur_d;
      in_idx_q   <= in_idx_d;
      neu_idx_q  <= neu_idx_d;
      acc_q      <= acc_d;
      ret_q      <= ret_d;
    end
  end

  assign bus.ap_idle   = (state_q == S_IDLE);
  assign bus.ap_done   = (state_q == S_DONE);
  assign bus.ap_ready  = (state_q == S_DONE);
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_ce    = rom_ce_q;
  assign bus.ap_return = ret_q;

endmodule
